// File: rtl/univ_shift_reg.sv
// Universal shift register with frame counter and shadow snapshot.
// Supports hold, shift left/right, rotate left/right, parallel load,
// synchronous clear and explicit snapshot. Every WIDTH shift/rotate ops
// the post-shift value is copied into Q_snap and Frame_done pulses once.
//
// Ports:
//   Clock      - rising-edge clock
//   Resetn     - asynchronous active-low reset
//   Mode       - operation select (3 bits)
//   Sin_l      - serial input for shift left, enters Q[0]
//   Sin_r      - serial input for shift right, enters Q[WIDTH-1]
//   Par_in     - parallel load data
//   Q          - main register
//   Q_snap     - shadow copy register
//   Count      - shift/rotate ops completed in the current frame
//   Frame_done - one-cycle pulse after the frame-completing edge
module univ_shift_reg #(
    parameter int unsigned      WIDTH     = 10,
    parameter int unsigned      CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [2:0]       Mode,
    input  logic             Sin_l,
    input  logic             Sin_r,
    input  logic [WIDTH-1:0] Par_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_snap,
    output logic [CNT_W-1:0] Count,
    output logic             Frame_done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_SNAP  = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mode_e            mode;
    logic [WIDTH-1:0] q_next;
    logic             is_shift;
    logic             cnt_clr;
    logic             take_snap;

    assign mode = mode_e'(Mode);

    // Next-value decode for Q plus counter/snapshot control.
    always_comb begin
        q_next    = Q;
        is_shift  = 1'b0;
        cnt_clr   = 1'b0;
        take_snap = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_next = Q;
            end
            MODE_SHL: begin
                q_next   = {Q[WIDTH-2:0], Sin_l};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_next   = {Sin_r, Q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_next   = {Q[WIDTH-2:0], Q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_next   = {Q[0], Q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                q_next  = Par_in;
                cnt_clr = 1'b1;
            end
            MODE_CLEAR: begin
                q_next  = '0;
                cnt_clr = 1'b1;
            end
            MODE_SNAP: begin
                take_snap = 1'b1;
            end
            default: begin
                q_next = Q;
            end
        endcase
    end

    // State registers; frame completion captures the post-shift value.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q          <= RESET_VAL;
            Q_snap     <= '0;
            Count      <= '0;
            Frame_done <= 1'b0;
        end else begin
            Q          <= q_next;
            Frame_done <= 1'b0;
            if (is_shift) begin
                if (Count == CNT_LAST) begin
                    Count      <= '0;
                    Q_snap     <= q_next;
                    Frame_done <= 1'b1;
                end else begin
                    Count <= Count + CNT_W'(1);
                end
            end else if (cnt_clr) begin
                Count <= '0;
            end
            if (take_snap) begin
                Q_snap <= Q;
            end
        end
    end

endmodule
